// File: rtl/rggen_wide_register_common.sv
// rtl/rggen_wide_register_common.sv - wide register front end: multi-word decode, wait states, atomic write buffer and read snapshot
module rggen_wide_register_common #(
    parameter bit                     READABLE             = 1'b1,
    parameter bit                     WRITABLE             = 1'b1,
    parameter int                     ADDRESS_WIDTH        = 8,
    parameter bit [ADDRESS_WIDTH-1:0] OFFSET_ADDRESS       = '0,
    parameter int                     BUS_WIDTH            = 32,
    parameter int                     DATA_WIDTH           = BUS_WIDTH,
    parameter bit                     ATOMIC_WRITE         = 1'b0,
    parameter bit                     ATOMIC_READ          = 1'b0,
    parameter int                     WAIT_CYCLES          = 0,
    parameter bit                     USE_ADDITIONAL_MATCH = 1'b0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_register_valid,
    input  logic [1:0]               i_register_access,
    input  logic [ADDRESS_WIDTH-1:0] i_register_address,
    input  logic [BUS_WIDTH-1:0]     i_register_write_data,
    input  logic [BUS_WIDTH-1:0]     i_register_strobe,
    input  logic                     i_additional_match,
    output logic                     o_register_active,
    output logic                     o_register_ready,
    output logic [1:0]               o_register_status,
    output logic [BUS_WIDTH-1:0]     o_register_read_data,
    output logic [DATA_WIDTH-1:0]    o_register_value,
    output logic                     o_write_pending,
    output logic                     o_bit_field_write_valid,
    output logic                     o_bit_field_read_valid,
    output logic [DATA_WIDTH-1:0]    o_bit_field_mask,
    output logic [DATA_WIDTH-1:0]    o_bit_field_write_data,
    input  logic [DATA_WIDTH-1:0]    i_bit_field_read_data,
    input  logic [DATA_WIDTH-1:0]    i_bit_field_value
);

    localparam int WORDS      = DATA_WIDTH / BUS_WIDTH;
    localparam int BYTES      = BUS_WIDTH / 8;
    localparam int LSB        = $clog2(BYTES);
    localparam int IDX_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam bit ATOMIC_W   = ATOMIC_WRITE && (WORDS > 1);
    localparam bit ATOMIC_R   = ATOMIC_READ && (WORDS > 1);
    localparam logic [3:0]            WAIT_LIMIT = 4'(WAIT_CYCLES);
    localparam logic [IDX_W-1:0]      LAST_INDEX = IDX_W'(WORDS - 1);
    // Bit-select of the most significant bus word of the register.
    localparam logic [DATA_WIDTH-1:0] TOP_SEL    = ~({DATA_WIDTH{1'b1}} >> BUS_WIDTH);

    function automatic logic [ADDRESS_WIDTH-1:0] word_address(input int k);
        return OFFSET_ADDRESS + ADDRESS_WIDTH'(k * BYTES);
    endfunction

    logic                  is_write;
    logic                  access_ok;
    logic                  qualifier_ok;
    logic [WORDS-1:0]      word_match;
    logic [IDX_W-1:0]      word_index;
    logic                  completion;
    logic [3:0]            wait_count;
    logic [DATA_WIDTH-1:0] word_sel;
    logic [DATA_WIDTH-1:0] strobe_rep;
    logic [DATA_WIDTH-1:0] wdata_rep;
    logic [DATA_WIDTH-1:0] slice_mask;
    logic [DATA_WIDTH-1:0] buffer_data;
    logic [DATA_WIDTH-1:0] buffer_mask;
    logic                  pending;
    logic [DATA_WIDTH-1:0] snapshot;
    logic [DATA_WIDTH-1:0] read_source;
    logic [BUS_WIDTH-1:0]  read_word;
    logic                  is_last_word;
    logic                  is_first_word;
    logic                  write_valid;
    logic                  read_valid;
    logic                  buffer_update;
    logic                  snapshot_update;
    logic                  use_snapshot;
    logic                  unused_inputs;

    assign is_write     = i_register_access[0];
    assign access_ok    = is_write ? WRITABLE : READABLE;
    assign qualifier_ok = !USE_ADDITIONAL_MATCH || i_additional_match;

    always_comb begin
        word_match = '0;
        for (int k = 0; k < WORDS; k++) begin
            word_match[k] = ((i_register_address >> LSB) == (word_address(k) >> LSB));
        end
    end

    always_comb begin
        word_index = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (word_match[k]) begin
                word_index = IDX_W'(k);
            end
        end
    end

    assign o_register_active = i_register_valid && access_ok && qualifier_ok && (|word_match);
    assign completion        = o_register_active && (wait_count == WAIT_LIMIT);

    // The counter only runs while a matching request is held; any gap restarts it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wait_count <= '0;
        end else if (!o_register_active || completion) begin
            wait_count <= '0;
        end else if (wait_count < WAIT_LIMIT) begin
            wait_count <= wait_count + 4'd1;
        end
    end

    assign is_last_word  = (word_index == LAST_INDEX);
    assign is_first_word = (word_index == '0);

    always_comb begin
        word_sel = '0;
        word_sel[int'(word_index)*BUS_WIDTH +: BUS_WIDTH] = '1;
    end

    assign strobe_rep = {WORDS{i_register_strobe}};
    assign wdata_rep  = {WORDS{i_register_write_data}};
    assign slice_mask = strobe_rep & word_sel;

    assign write_valid     = completion && is_write && (!ATOMIC_W || is_last_word);
    assign buffer_update   = completion && is_write && ATOMIC_W && !is_last_word;
    assign read_valid      = completion && !is_write && (!ATOMIC_R || is_first_word);
    assign snapshot_update = completion && !is_write && ATOMIC_R && is_first_word;
    assign use_snapshot    = ATOMIC_R && !is_first_word;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            buffer_data <= '0;
            buffer_mask <= '0;
            pending     <= 1'b0;
        end else if (buffer_update) begin
            buffer_data <= (buffer_data & ~slice_mask) | (wdata_rep & slice_mask);
            buffer_mask <= buffer_mask | slice_mask;
            pending     <= 1'b1;
        end else if (write_valid && ATOMIC_W) begin
            buffer_data <= '0;
            buffer_mask <= '0;
            pending     <= 1'b0;
        end
    end

    // Slice 0 of the snapshot is captured too but never selected.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            snapshot <= '0;
        end else if (snapshot_update) begin
            snapshot <= i_bit_field_read_data;
        end
    end

    always_comb begin
        o_bit_field_mask       = '0;
        o_bit_field_write_data = '0;
        if (write_valid) begin
            if (ATOMIC_W) begin
                o_bit_field_mask       = (buffer_mask & ~TOP_SEL) | slice_mask;
                o_bit_field_write_data = (buffer_data & ~TOP_SEL) | (wdata_rep & TOP_SEL);
            end else begin
                o_bit_field_mask       = slice_mask;
                o_bit_field_write_data = wdata_rep;
            end
        end
    end

    assign read_source = use_snapshot ? snapshot : i_bit_field_read_data;
    assign read_word   = read_source[int'(word_index)*BUS_WIDTH +: BUS_WIDTH];

    assign o_register_ready        = completion;
    assign o_register_status       = 2'b00;
    assign o_register_read_data    = (completion && !is_write) ? read_word : '0;
    assign o_register_value        = i_bit_field_value;
    assign o_write_pending         = pending;
    assign o_bit_field_write_valid = write_valid;
    assign o_bit_field_read_valid  = read_valid;

    assign unused_inputs = i_register_access[1];

endmodule

// File: tb/tb_rggen_wide_register_common.sv
// tb/tb_rggen_wide_register_common.sv - scoreboard bench for rggen_wide_register_common
module tb_rggen_wide_register_common;

    typedef struct {
        int          inst;
        logic [31:0] rdata;
        logic        wv;
        logic        rv;
        logic [63:0] mask;
        logic [63:0] wdata;
        int          lat;
        int          issue;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid [3];
    logic [1:0]  access = 2'b00;
    logic [7:0]  address = 8'h00;
    logic [31:0] wdata = '0;
    logic [31:0] strobe = '0;
    logic        add_match = 1'b1;
    logic [63:0] rd_data = '0;
    logic [63:0] value = '0;

    logic        active [3];
    logic        ready [3];
    logic [1:0]  status [3];
    logic [31:0] rdata [3];
    logic [63:0] reg_value [3];
    logic        pending [3];
    logic        wv [3];
    logic        rv [3];
    logic [63:0] mask [3];
    logic [63:0] bf_wdata [3];

    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    int   wv_cnt [3] = '{0, 0, 0};
    int   rv_cnt [3] = '{0, 0, 0};
    exp_t sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rggen_wide_register_common #(
        .ADDRESS_WIDTH(8), .OFFSET_ADDRESS(8'h10), .BUS_WIDTH(32), .DATA_WIDTH(64),
        .ATOMIC_WRITE(1'b0), .ATOMIC_READ(1'b0), .WAIT_CYCLES(0)
    ) dut_plain (
        .i_clk(clk), .i_rst(rst), .i_register_valid(valid[0]), .i_register_access(access),
        .i_register_address(address), .i_register_write_data(wdata), .i_register_strobe(strobe),
        .i_additional_match(add_match), .o_register_active(active[0]), .o_register_ready(ready[0]),
        .o_register_status(status[0]), .o_register_read_data(rdata[0]), .o_register_value(reg_value[0]),
        .o_write_pending(pending[0]), .o_bit_field_write_valid(wv[0]), .o_bit_field_read_valid(rv[0]),
        .o_bit_field_mask(mask[0]), .o_bit_field_write_data(bf_wdata[0]),
        .i_bit_field_read_data(rd_data), .i_bit_field_value(value)
    );

    rggen_wide_register_common #(
        .ADDRESS_WIDTH(8), .OFFSET_ADDRESS(8'h10), .BUS_WIDTH(32), .DATA_WIDTH(64),
        .ATOMIC_WRITE(1'b1), .ATOMIC_READ(1'b1), .WAIT_CYCLES(0)
    ) dut_atomic (
        .i_clk(clk), .i_rst(rst), .i_register_valid(valid[1]), .i_register_access(access),
        .i_register_address(address), .i_register_write_data(wdata), .i_register_strobe(strobe),
        .i_additional_match(add_match), .o_register_active(active[1]), .o_register_ready(ready[1]),
        .o_register_status(status[1]), .o_register_read_data(rdata[1]), .o_register_value(reg_value[1]),
        .o_write_pending(pending[1]), .o_bit_field_write_valid(wv[1]), .o_bit_field_read_valid(rv[1]),
        .o_bit_field_mask(mask[1]), .o_bit_field_write_data(bf_wdata[1]),
        .i_bit_field_read_data(rd_data), .i_bit_field_value(value)
    );

    rggen_wide_register_common #(
        .ADDRESS_WIDTH(8), .OFFSET_ADDRESS(8'h10), .BUS_WIDTH(32), .DATA_WIDTH(64),
        .ATOMIC_WRITE(1'b0), .ATOMIC_READ(1'b0), .WAIT_CYCLES(3)
    ) dut_wait (
        .i_clk(clk), .i_rst(rst), .i_register_valid(valid[2]), .i_register_access(access),
        .i_register_address(address), .i_register_write_data(wdata), .i_register_strobe(strobe),
        .i_additional_match(add_match), .o_register_active(active[2]), .o_register_ready(ready[2]),
        .o_register_status(status[2]), .o_register_read_data(rdata[2]), .o_register_value(reg_value[2]),
        .o_write_pending(pending[2]), .o_bit_field_write_valid(wv[2]), .o_bit_field_read_valid(rv[2]),
        .o_bit_field_mask(mask[2]), .o_bit_field_write_data(bf_wdata[2]),
        .i_bit_field_read_data(rd_data), .i_bit_field_value(value)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ready from any instance must match the head of the scoreboard.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (wv[i]) wv_cnt[i] <= wv_cnt[i] + 1;
            if (rv[i]) rv_cnt[i] <= rv_cnt[i] + 1;
            if (ready[i] === 1'b1) begin
                if (sb.size() == 0 || sb[0].inst != i) begin
                    check($sformatf("unexpected_ready[%0d]", i), 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("latency[%0d]", i), 64'(cyc - e.issue), 64'(e.lat));
                    check($sformatf("read_data[%0d]", i), 64'(rdata[i]), 64'(e.rdata));
                    check($sformatf("write_valid[%0d]", i), 64'(wv[i]), 64'(e.wv));
                    check($sformatf("read_valid[%0d]", i), 64'(rv[i]), 64'(e.rv));
                    check($sformatf("mask[%0d]", i), mask[i], e.mask);
                    check($sformatf("write_data[%0d]", i), bf_wdata[i], e.wdata);
                end
            end
        end
    end

    task automatic issue(input int inst, input logic wr, input logic [7:0] addr,
                         input logic [31:0] data, input logic [31:0] strb,
                         input logic [31:0] erd, input logic ewv, input logic erv,
                         input logic [63:0] emask, input logic [63:0] ewd, input int lat);
        exp_t e;
        bit   seen;
        @(posedge clk);
        #1;
        access = {1'b0, wr};
        address = addr;
        wdata = data;
        strobe = strb;
        valid[inst] = 1'b1;
        e = '{inst: inst, rdata: erd, wv: ewv, rv: erv, mask: emask, wdata: ewd, lat: lat, issue: cyc};
        sb.push_back(e);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (ready[inst] === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            check($sformatf("timeout[%0d]", inst), 64'd0, 64'd1);
            void'(sb.pop_back());
        end
        @(posedge clk);
        #1;
        valid[inst] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) valid[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_ready[%0d]", i), 64'(ready[i]), 64'd0);
            check($sformatf("reset_active[%0d]", i), 64'(active[i]), 64'd0);
            check($sformatf("reset_pending[%0d]", i), 64'(pending[i]), 64'd0);
            check($sformatf("status[%0d]", i), 64'(status[i]), 64'd0);
        end

        // Non-atomic instance, zero wait states
        value = 64'hFEDC_BA98_7654_3210;
        @(negedge clk);
        check("register_value", reg_value[0], 64'hFEDC_BA98_7654_3210);
        issue(0, 1'b1, 8'h10, 32'hAABBCCDD, 32'hFFFF0000, 32'h0, 1'b1, 1'b0,
              64'h0000_0000_FFFF_0000, 64'hAABBCCDD_AABBCCDD, 0);
        issue(0, 1'b1, 8'h14, 32'h12345678, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0,
              64'hFFFF_FFFF_0000_0000, 64'h12345678_12345678, 0);
        rd_data = 64'h5555AAAA_12345678;
        issue(0, 1'b0, 8'h14, 32'h0, 32'h0, 32'h5555AAAA, 1'b0, 1'b1, 64'h0, 64'h0, 0);

        // Out-of-range address must never match
        @(posedge clk);
        #1;
        access = 2'b01;
        address = 8'h18;
        valid[0] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("nomatch_active", 64'(active[0]), 64'd0);
        end
        @(posedge clk);
        #1;
        valid[0] = 1'b0;

        // Atomic write: full words, then partial byte merges
        issue(1, 1'b1, 8'h10, 32'h11111111, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 64'h0, 64'h0, 0);
        check("pending_after_low", 64'(pending[1]), 64'd1);
        issue(1, 1'b1, 8'h14, 32'h22222222, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFF, 64'h22222222_11111111, 0);
        check("pending_after_commit", 64'(pending[1]), 64'd0);
        issue(1, 1'b1, 8'h10, 32'h00000001, 32'h000000FF, 32'h0, 1'b0, 1'b0, 64'h0, 64'h0, 0);
        issue(1, 1'b1, 8'h10, 32'h00000002, 32'h000000FF, 32'h0, 1'b0, 1'b0, 64'h0, 64'h0, 0);
        issue(1, 1'b1, 8'h14, 32'h33333333, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0,
              64'hFFFF_FFFF_0000_00FF, 64'h33333333_00000002, 0);

        // Atomic read: high word comes from the snapshot, not the live data
        rd_data = 64'h5555AAAA_12345678;
        issue(1, 1'b0, 8'h10, 32'h0, 32'h0, 32'h12345678, 1'b0, 1'b1, 64'h0, 64'h0, 0);
        rd_data = 64'h0;
        issue(1, 1'b0, 8'h14, 32'h0, 32'h0, 32'h5555AAAA, 1'b0, 1'b0, 64'h0, 64'h0, 0);

        // Reset while a write is buffered discards buffer and snapshot
        issue(1, 1'b1, 8'h10, 32'h44444444, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 64'h0, 64'h0, 0);
        check("pending_before_reset", 64'(pending[1]), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("pending_after_reset", 64'(pending[1]), 64'd0);
        issue(1, 1'b1, 8'h14, 32'h66666666, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0,
              64'hFFFF_FFFF_0000_0000, 64'h66666666_00000000, 0);
        rd_data = 64'hDEADBEEF_CAFEBABE;
        issue(1, 1'b1 ^ 1'b1, 8'h14, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 64'h0, 64'h0, 0);

        // Wait states: three cycles, abort restarts the counter
        issue(2, 1'b1, 8'h10, 32'hCAFEF00D, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0,
              64'h0000_0000_FFFF_FFFF, 64'hCAFEF00D_CAFEF00D, 3);
        @(posedge clk);
        #1;
        access = 2'b01;
        address = 8'h10;
        valid[2] = 1'b1;
        @(posedge clk);
        #1;
        valid[2] = 1'b0;
        rd_data = 64'h0BADBEEF_00C0FFEE;
        issue(2, 1'b0, 8'h14, 32'h0, 32'h0, 32'h0BADBEEF, 1'b0, 1'b1, 64'h0, 64'h0, 3);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        check("write_pulses[0]", 64'(wv_cnt[0]), 64'd2);
        check("read_pulses[0]", 64'(rv_cnt[0]), 64'd1);
        check("write_pulses[1]", 64'(wv_cnt[1]), 64'd3);
        check("read_pulses[1]", 64'(rv_cnt[1]), 64'd1);
        check("write_pulses[2]", 64'(wv_cnt[2]), 64'd1);
        check("read_pulses[2]", 64'(rv_cnt[2]), 64'd1);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
